// File: rtl/cursor_sched_pkg.sv
// cursor_sched_pkg: shared types and constants for the cursor smoothing scheduler
package cursor_sched_pkg;
  typedef enum logic [1:0] {IDLE, MUL_X, MUL_Y, DONE} state_t;
  localparam int Q8_SHIFT = 8;
  localparam int COORD_W = 16;
  localparam int ACC_W = 32;
  localparam logic signed [COORD_W-1:0] ALPHA_DEFAULT = 16'sd51;
endpackage

// File: rtl/cursor_rr_arbiter.sv
// cursor_rr_arbiter: picks the first requester strictly after last_i, searching cyclically
module cursor_rr_arbiter #(
  parameter int N_CH = 4,
  localparam int IW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    for (int k = N_CH; k >= 1; k--)
      if (req_i[(int'(last_i) + k) % N_CH]) idx_o = IW'((int'(last_i) + k) % N_CH);
    gnt_o = N_CH'(any_o) << idx_o;
  end
endmodule

// File: rtl/cursor_smooth_sched.sv
// cursor_smooth_sched: round-robin scheduled per-channel IIR cursor smoothing on one shared multiplier
module cursor_smooth_sched
  import cursor_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter logic signed [COORD_W-1:0] ALPHA_RESET = ALPHA_DEFAULT,
  localparam int IW = $clog2(N_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           in_valid,
  output logic [N_CH-1:0]           in_ready,
  input  logic [COORD_W*N_CH-1:0]   in_x,
  input  logic [COORD_W*N_CH-1:0]   in_y,
  input  logic                      cfg_alpha_we,
  input  logic [COORD_W-1:0]        cfg_alpha,
  input  logic [N_CH-1:0]           ch_clear,
  output logic                      out_valid,
  output logic [IW-1:0]             out_ch,
  output logic [COORD_W-1:0]        out_x,
  output logic [COORD_W-1:0]        out_y
);
  state_t state_q, state_d;
  logic [IW-1:0] last_q, g_q, gi;
  logic [N_CH-1:0] gnt;
  logic any, cancel_q, cancel;
  logic signed [COORD_W-1:0] sx_mem_q [N_CH];
  logic signed [COORD_W-1:0] sy_mem_q [N_CH];
  logic signed [COORD_W-1:0] rx_q, ry_q, sx_q, sy_q, wx_q, wy_q;
  logic signed [COORD_W-1:0] alpha_shadow_q, alpha_act_q, r_op, s_op, w;
  logic signed [ACC_W-1:0] diff, prod;

  cursor_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req_i(in_valid), .last_i(last_q), .gnt_o(gnt), .idx_o(gi), .any_o(any)
  );

  assign in_ready = state_q == IDLE ? gnt : '0;
  assign cancel = cancel_q | ch_clear[g_q];

  always_comb begin
    state_d = state_q == IDLE ? (any ? MUL_X : IDLE) :
              state_q == MUL_X ? MUL_Y :
              state_q == MUL_Y ? DONE : IDLE;
  end

  // The single multiplier serves x in MUL_X and y in MUL_Y.
  always_comb begin
    r_op = state_q == MUL_X ? rx_q : ry_q;
    s_op = state_q == MUL_X ? sx_q : sy_q;
    diff = ACC_W'(r_op) - ACC_W'(s_op);
    prod = diff * ACC_W'(alpha_act_q);
    w = COORD_W'(ACC_W'(s_op) + (prod >>> Q8_SHIFT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= IW'(N_CH - 1);
      alpha_shadow_q <= ALPHA_RESET;
      alpha_act_q <= ALPHA_RESET;
      cancel_q <= 1'b0;
      out_valid <= 1'b0;
      out_ch <= '0;
      out_x <= '0;
      out_y <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sx_mem_q[i] <= '0;
        sy_mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      out_valid <= state_q == DONE;
      if (cfg_alpha_we) alpha_shadow_q <= cfg_alpha;
      if (state_q == IDLE && any) begin
        g_q <= gi;
        rx_q <= in_x[COORD_W*gi +: COORD_W];
        ry_q <= in_y[COORD_W*gi +: COORD_W];
        sx_q <= sx_mem_q[gi];
        sy_q <= sy_mem_q[gi];
        alpha_act_q <= alpha_shadow_q;
        cancel_q <= ch_clear[gi];
      end
      if (state_q == MUL_X) begin
        wx_q <= w;
        cancel_q <= cancel;
      end
      if (state_q == MUL_Y) begin
        wy_q <= w;
        cancel_q <= cancel;
      end
      if (state_q == DONE) begin
        out_ch <= g_q;
        out_x <= cancel ? '0 : wx_q;
        out_y <= cancel ? '0 : wy_q;
        last_q <= g_q;
        if (!cancel) begin
          sx_mem_q[g_q] <= wx_q;
          sy_mem_q[g_q] <= wy_q;
        end
      end
      // Placed after the writeback so a same-edge clear wins.
      for (int i = 0; i < N_CH; i++)
        if (ch_clear[i]) begin
          sx_mem_q[i] <= '0;
          sy_mem_q[i] <= '0;
        end
    end
  end
endmodule

// File: tb/tb_cursor_smooth_sched.sv
// tb_cursor_smooth_sched: randomized scoreboard bench with a transaction-level smoothing model
module tb_cursor_smooth_sched;
  localparam int N = 4;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] in_valid = '0, in_ready, ch_clear = '0;
  logic [16*N-1:0] in_x = '0, in_y = '0;
  logic cfg_alpha_we = 1'b0;
  logic [15:0] cfg_alpha = '0;
  logic out_valid;
  logic [IW-1:0] out_ch;
  logic [15:0] out_x, out_y;

  always #5 clk = ~clk;

  cursor_smooth_sched #(.N_CH(N), .ALPHA_RESET(16'sd51)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .cfg_alpha_we(cfg_alpha_we), .cfg_alpha(cfg_alpha),
    .ch_clear(ch_clear), .out_valid(out_valid), .out_ch(out_ch), .out_x(out_x), .out_y(out_y)
  );

  typedef struct {int ch; int x; int y; int due;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;

  int mst_x[N], mst_y[N];
  int shadow, act, last, phase, g, rx, ry, lsx, lsy;
  bit canc, granted;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic int filt(int r, int s, int a);
    longint p;
    logic signed [15:0] res;
    p = (longint'(r) - longint'(s)) * longint'(a);
    p = p >>> 8;
    res = 16'(longint'(s) + p);
    return int'(res);
  endfunction

  function automatic int sx16(logic [15:0] v);
    return int'($signed(v));
  endfunction

  // One filter operation: grant, x step, y step, writeback/report; clears and reset observed per edge.
  task automatic model_step();
    int exp_rdy;
    exp_rdy = 0;
    granted = 0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin mst_x[i] = 0; mst_y[i] = 0; end
      shadow = 51; act = 51; last = N - 1; phase = 0;
      return;
    end
    if (phase == 0) begin
      if (|in_valid) begin
        for (int k = N; k >= 1; k--) if (in_valid[(last + k) % N]) g = (last + k) % N;
        exp_rdy = 1 << g;
        rx = sx16(in_x[16*g +: 16]); ry = sx16(in_y[16*g +: 16]);
        lsx = mst_x[g]; lsy = mst_y[g];
        act = shadow; canc = ch_clear[g]; phase = 1; granted = 1;
      end
    end else if (phase < 3) begin
      canc |= ch_clear[g];
      phase++;
    end else begin
      exp_t e;
      canc |= ch_clear[g];
      e.ch = g;
      e.x = canc ? 0 : filt(rx, lsx, act);
      e.y = canc ? 0 : filt(ry, lsy, act);
      e.due = cyc + 1;
      if (!canc) begin mst_x[g] = e.x; mst_y[g] = e.y; end
      q.push_back(e);
      last = g; phase = 0;
    end
    chk("in_ready", int'(in_ready), exp_rdy);
    for (int i = 0; i < N; i++) if (ch_clear[i]) begin mst_x[i] = 0; mst_y[i] = 0; end
    if (cfg_alpha_we) shadow = sx16(cfg_alpha);
  endtask

  initial forever begin
    @(negedge clk);
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got out_valid=1 expected no result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_ch", int'(out_ch), e.ch);
        chk("out_x", sx16(out_x), e.x);
        chk("out_y", sx16(out_y), e.y);
        chk("out_time", cyc, e.due);
      end
    end
  end

  task automatic tick();
    #1 model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(int ch, int x, int y, int we_at, int alpha, int clr_at);
    int n;
    in_valid = N'(1) << ch;
    in_x[16*ch +: 16] = 16'(x);
    in_y[16*ch +: 16] = 16'(y);
    n = 0;
    do begin tick(); n++; end while (!granted && n < 20);
    in_valid = '0;
    if (!granted) begin chk("grant_timeout", 0, 1); return; end
    for (int k = 0; k < 4; k++) begin
      cfg_alpha_we = k == we_at;
      cfg_alpha = 16'(alpha);
      ch_clear = k == clr_at ? N'(1) << ch : '0;
      tick();
    end
    cfg_alpha_we = 0;
    ch_clear = '0;
  endtask

  task automatic prep(logic [N-1:0] clr, int alpha);
    ch_clear = clr; cfg_alpha_we = 1; cfg_alpha = 16'(alpha);
    tick();
    ch_clear = '0; cfg_alpha_we = 0;
  endtask

  initial begin
    @(negedge clk); #1;
    tick(); tick();
    rst = 0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_x", sx16(out_x), 0);
    chk("rst_out_y", sx16(out_y), 0);
    tick();
    send(0, 1000, -1000, -1, 0, -1);
    chk("basic_x", sx16(out_x), 199);
    chk("basic_y", sx16(out_y), -200);
    in_valid = '1;
    for (int t = 0; t < 40; t++) begin
      in_x = {$urandom, $urandom}; in_y = {$urandom, $urandom};
      tick();
    end
    in_valid = '0;
    for (int t = 0; t < 5; t++) tick();
    prep(4'b0100, 128);
    foreach (mst_x[i]) ;
    for (int k = 0; k < 4; k++) send(2, 1000, 1000, -1, 0, -1);
    chk("seq_x", sx16(out_x), 937);
    chk("seq_y", sx16(out_y), 937);
    prep(4'b0001, 51);
    send(0, 1000, 1000, 0, 256, -1);
    chk("alpha_inflight", sx16(out_x), 199);
    send(0, 1000, 1000, -1, 0, -1);
    chk("alpha_next", sx16(out_x), 1000);
    prep(4'b0010, 128);
    send(1, 1000, 1000, -1, 0, -1);
    chk("ch1_pre", sx16(out_x), 500);
    prep(4'b0000, 51);
    send(1, 1000, 1000, -1, 0, 1);
    chk("cancel_x", sx16(out_x), 0);
    chk("cancel_y", sx16(out_y), 0);
    send(1, 1000, 1000, -1, 0, -1);
    chk("after_cancel", sx16(out_x), 199);
    prep(4'b0000, 256);
    in_valid = 4'b0100; tick();
    in_valid = '0; rst = 1; tick(); tick();
    rst = 0;
    in_x[16 +: 16] = 16'd1000; in_y[16 +: 16] = 16'd1000;
    in_valid = 4'b1010; tick();
    in_valid = '0;
    for (int t = 0; t < 4; t++) tick();
    chk("rst_first_ch", int'(out_ch), 1);
    chk("rst_alpha_x", sx16(out_x), 199);
    for (int t = 0; t < 500; t++) begin
      in_valid = N'($urandom);
      in_x = {$urandom, $urandom}; in_y = {$urandom, $urandom};
      cfg_alpha_we = ($urandom % 12) == 0;
      cfg_alpha = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 256));
      ch_clear = ($urandom % 8) == 0 ? N'($urandom) : '0;
      rst = ($urandom % 150) == 0;
      tick();
    end
    in_valid = '0; cfg_alpha_we = 0; ch_clear = '0; rst = 0;
    for (int t = 0; t < 8; t++) tick();
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
